// File: rtl/md_sched_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// MD op codes, FSM state codes, and op classification helpers (madd family gated by MD_MADD_EN).
package md_sched_pkg;

   typedef enum logic [3:0] {
      MD_MULT  = 4'd0,
      MD_MULTU = 4'd1,
      MD_DIV   = 4'd2,
      MD_DIVU  = 4'd3,
      MD_MTHI  = 4'd4,
      MD_MTLO  = 4'd5,
      MD_MADD  = 4'd6,
      MD_MADDU = 4'd7,
      MD_MSUB  = 4'd8,
      MD_MSUBU = 4'd9
   } md_op_e;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } md_hilo_t;

   // Ops that occupy the unit for a multi-cycle busy window.
   function automatic logic md_is_long(input logic [3:0] op);
      case (op)
         MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_MADD_EN
         MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic md_is_div(input logic [3:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

   function automatic logic md_is_move(input logic [3:0] op);
      return (op == MD_MTHI) || (op == MD_MTLO);
   endfunction

endpackage

// File: rtl/md_sched_if.sv
// E-stage <-> MD unit signal bundle: op request, D-stage use flag, HI/LO and status back.
// master drives the request side (pipeline), slave is the sequencer.
interface md_sched_if;
   logic        start;
   logic [3:0]  md_op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        md_use_d;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;
   logic        stall_md;

   modport master (
      output start, md_op, rs_val, rt_val, md_use_d,
      input  hi, lo, busy, stall_md
   );

   modport slave (
      input  start, md_op, rs_val, rt_val, md_use_d,
      output hi, lo, busy, stall_md
   );
endinterface

// File: rtl/md_sched_alu.sv
// md_alu: combinational HI/LO result for one MD op (mult/div/moves; madd family when MD_MADD_EN).
// Latency: zero, pure combinational.
// Backpressure: none; caller decides when to capture the result.
module md_alu
   import md_sched_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] cur_hi,
   input  logic [31:0] cur_lo,
   output logic [31:0] res_hi,
   output logic [31:0] res_lo,
   output logic        div0
);

   logic        sgn;
   logic [63:0] ext_a;
   logic [63:0] ext_b;
   logic [63:0] prod;
   logic [31:0] b_nz;
   logic signed [31:0] a_s;
   logic signed [31:0] b_s;
   logic signed [31:0] q_s;
   logic signed [31:0] r_s;
   logic [31:0] q_u;
   logic [31:0] r_u;
   md_hilo_t    cur;
   md_hilo_t    res;

   always_comb begin
      case (op)
         MD_MULT, MD_DIV, MD_MADD, MD_MSUB: sgn = 1'b1;
         default:                           sgn = 1'b0;
      endcase
   end

   // One 64x64 multiplier: low 64 bits of the extended product are correct for both signednesses.
   assign ext_a = {{32{sgn & a[31]}}, a};
   assign ext_b = {{32{sgn & b[31]}}, b};
   assign prod  = ext_a * ext_b;

   // Divisor forced non-zero so the divider never sees zero; div0 suppresses the commit instead.
   assign b_nz = (b == 32'd0) ? 32'd1 : b;
   assign a_s  = a;
   assign b_s  = b_nz;
   assign q_s  = a_s / b_s;
   assign r_s  = a_s % b_s;
   assign q_u  = a / b_nz;
   assign r_u  = a % b_nz;

   assign cur = '{hi: cur_hi, lo: cur_lo};

   always_comb begin
      res  = cur;
      div0 = 1'b0;
      case (op)
         MD_MULT, MD_MULTU: res = prod;
         MD_DIV: begin
            res  = '{hi: r_s, lo: q_s};
            div0 = (b == 32'd0);
         end
         MD_DIVU: begin
            res  = '{hi: r_u, lo: q_u};
            div0 = (b == 32'd0);
         end
         MD_MTHI: res.hi = a;
         MD_MTLO: res.lo = a;
`ifdef MD_MADD_EN
         MD_MADD, MD_MADDU: res = cur + prod;
         MD_MSUB, MD_MSUBU: res = cur - prod;
`endif
         default: res = cur;
      endcase
   end

   assign res_hi = res.hi;
   assign res_lo = res.lo;

endmodule

// File: rtl/md_sched.sv
// md_sched: HI/LO multiply/divide sequencer; optional madd/msub family under MD_MADD_EN.
// Latency: long op started in cycle T commits HI/LO at the end of cycle T+N; mthi/mtlo next edge.
// Backpressure: stall_md = md_use_d & (start | busy); starts while busy are dropped.
module md_sched
   import md_sched_pkg::*;
#(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
)
(
   input  logic       clk,
   input  logic       reset_n,
   md_sched_if.slave  md
);

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   md_state_e   state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   md_hilo_t    pend_q, pend_d;
   logic        pend_div0_q, pend_div0_d;
   md_hilo_t    hilo_q, hilo_d;

   logic [31:0] alu_hi;
   logic [31:0] alu_lo;
   logic        alu_div0;

   md_alu u_alu (
      .op     (md.md_op),
      .a      (md.rs_val),
      .b      (md.rt_val),
      .cur_hi (hilo_q.hi),
      .cur_lo (hilo_q.lo),
      .res_hi (alu_hi),
      .res_lo (alu_lo),
      .div0   (alu_div0)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= MD_IDLE;
         cnt_q       <= 4'd0;
         pend_q      <= '0;
         pend_div0_q <= 1'b0;
         hilo_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         pend_div0_q <= pend_div0_d;
         hilo_q      <= hilo_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_d      = pend_q;
      pend_div0_d = pend_div0_q;
      hilo_d      = hilo_q;
      case (state_q)
         MD_IDLE: begin
            if (md.start) begin
               if (md_is_long(md.md_op)) begin
                  // Result is captured now; HI/LO cannot change while busy, so this equals commit-time value.
                  pend_d      = '{hi: alu_hi, lo: alu_lo};
                  pend_div0_d = alu_div0;
                  cnt_d       = md_is_div(md.md_op) ? DIV_N : MULT_N;
                  state_d     = MD_BUSY;
               end else if (md_is_move(md.md_op)) begin
                  hilo_d = '{hi: alu_hi, lo: alu_lo};
               end
            end
         end
         MD_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               if (!pend_div0_q) begin
                  hilo_d = pend_q;
               end
               cnt_d   = 4'd0;
               state_d = MD_IDLE;
            end
         end
         default: begin
            state_d = MD_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   assign md.hi       = hilo_q.hi;
   assign md.lo       = hilo_q.lo;
   assign md.busy     = (state_q == MD_BUSY);
   assign md.stall_md = md.md_use_d & (md.start | md.busy);

endmodule

// File: tb/tb_md_sched.sv
// Randomized self-checking bench for md_sched against an arithmetic reference model.
module tb_md_sched;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_err;
   logic [31:0] m_hi;
   logic [31:0] m_lo;

   md_sched_if mif ();

   md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .md      (mif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: result from the architectural definition; n = busy cycles (0 = effect at next edge).
   function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] ch, input logic [31:0] cl,
                                  output logic [31:0] nh, output logic [31:0] nl, output int n);
      longint sa, sb, ma, mb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      nh = ch;
      nl = cl;
      n  = 0;
      case (op)
         4'd0: begin p = 64'(sa * sb); {nh, nl} = p; n = MULT_N; end
         4'd1: begin p = {32'd0, a} * {32'd0, b}; {nh, nl} = p; n = MULT_N; end
         4'd2: begin
            n = DIV_N;
            if (b != 0) begin
               ma = (sa < 0) ? -sa : sa;
               mb = (sb < 0) ? -sb : sb;
               q  = ma / mb;
               if ((sa < 0) != (sb < 0)) q = -q;
               r  = sa - q * sb;
               nl = q[31:0];
               nh = r[31:0];
            end
         end
         4'd3: begin
            n = DIV_N;
            if (b != 0) begin nl = a / b; nh = a % b; end
         end
         4'd4: nh = a;
         4'd5: nl = a;
`ifdef MD_MADD_EN
         4'd6: begin p = 64'(sa * sb); {nh, nl} = {ch, cl} + p; n = MULT_N; end
         4'd7: begin p = {32'd0, a} * {32'd0, b}; {nh, nl} = {ch, cl} + p; n = MULT_N; end
         4'd8: begin p = 64'(sa * sb); {nh, nl} = {ch, cl} - p; n = MULT_N; end
         4'd9: begin p = {32'd0, a} * {32'd0, b}; {nh, nl} = {ch, cl} - p; n = MULT_N; end
`endif
         default: ;
      endcase
   endfunction

   // Called at a negedge with the unit idle; returns at the negedge of the cycle after the effect.
   task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic inject);
      logic [31:0] eh, el;
      int n;
      ref_op(op, a, b, m_hi, m_lo, eh, el, n);
      mif.start    = 1'b1;
      mif.md_op    = op;
      mif.rs_val   = a;
      mif.rt_val   = b;
      mif.md_use_d = use_d;
      #1;
      chk("start_busy", 64'(mif.busy), 64'(0));
      chk("start_stall", 64'(mif.stall_md), 64'(use_d));
      @(negedge clk);
      for (int i = 1; i <= n; i++) begin
         chk("busy_on", 64'(mif.busy), 64'(1));
         chk("busy_hilo", {mif.hi, mif.lo}, {m_hi, m_lo});
         mif.start  = inject && (i == 2);
         mif.md_op  = 4'($urandom_range(0, 5));
         mif.rs_val = $urandom;
         mif.rt_val = $urandom;
         #1;
         chk("busy_stall", 64'(mif.stall_md), 64'(use_d));
         @(negedge clk);
      end
      mif.start = 1'b0;
      #1;
      chk("done_busy", 64'(mif.busy), 64'(0));
      chk("done_stall", 64'(mif.stall_md), 64'(0));
      chk("done_hilo", {mif.hi, mif.lo}, {eh, el});
      m_hi = eh;
      m_lo = el;
   endtask

   function automatic logic [31:0] rnd_val();
      case ($urandom_range(0, 3))
         0:       return 32'($urandom_range(0, 20));
         1:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      n_chk = 0;
      n_err = 0;
      m_hi = '0;
      m_lo = '0;
      reset_n      = 1'b0;
      mif.start    = 1'b0;
      mif.md_op    = '0;
      mif.rs_val   = '0;
      mif.rt_val   = '0;
      mif.md_use_d = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_hi", 64'(mif.hi), 64'(0));
      chk("rst_lo", 64'(mif.lo), 64'(0));
      chk("rst_busy", 64'(mif.busy), 64'(0));
      reset_n = 1'b1;
      @(negedge clk);

      do_op(4'd0, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b1);
      chk("mult_hi", 64'(mif.hi), 64'(32'hFFFFFFFF));
      chk("mult_lo", 64'(mif.lo), 64'(32'hFFFFFFF1));
      do_op(4'd3, 32'd7, 32'd2, 1'b0, 1'b0);
      chk("divu_hi", 64'(mif.hi), 64'(1));
      chk("divu_lo", 64'(mif.lo), 64'(3));
      do_op(4'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
      chk("div_hi", 64'(mif.hi), 64'(32'hFFFFFFFF));
      chk("div_lo", 64'(mif.lo), 64'(32'hFFFFFFFD));
      do_op(4'd4, 32'h11, 32'h0, 1'b0, 1'b0);
      do_op(4'd5, 32'h22, 32'h0, 1'b0, 1'b0);
      do_op(4'd2, 32'h1234, 32'h0, 1'b1, 1'b1);
      chk("div0_hi", 64'(mif.hi), 64'(32'h11));
      chk("div0_lo", 64'(mif.lo), 64'(32'h22));
      do_op(4'd4, 32'hABCD, 32'h0, 1'b0, 1'b0);
      chk("mthi_hi", 64'(mif.hi), 64'(32'hABCD));
      chk("mthi_lo", 64'(mif.lo), 64'(32'h22));
      do_op(4'd12, 32'h5, 32'h7, 1'b1, 1'b0);
`ifdef MD_MADD_EN
      do_op(4'd4, 32'h0, 32'h0, 1'b0, 1'b0);
      do_op(4'd5, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
      do_op(4'd7, 32'd1, 32'd1, 1'b0, 1'b0);
      chk("maddu_hi", 64'(mif.hi), 64'(1));
      chk("maddu_lo", 64'(mif.lo), 64'(0));
`endif

      // Reset in the third busy cycle of a divide.
      mif.start  = 1'b1;
      mif.md_op  = 4'd2;
      mif.rs_val = 32'd100;
      mif.rt_val = 32'd7;
      repeat (3) begin
         @(negedge clk);
         mif.start = 1'b0;
      end
      #1;
      chk("pre_rst_busy", 64'(mif.busy), 64'(1));
      reset_n = 1'b0;
      #1;
      chk("arst_busy", 64'(mif.busy), 64'(0));
      chk("arst_hilo", {mif.hi, mif.lo}, 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      m_hi = '0;
      m_lo = '0;
      @(negedge clk);
      chk("post_rst_busy", 64'(mif.busy), 64'(0));
      chk("post_rst_hilo", {mif.hi, mif.lo}, 64'(0));

      for (int k = 0; k < 150; k++) begin
         op = 4'($urandom_range(0, 15));
         if (op > 4'd11 && $urandom_range(0, 1) == 0) op = 4'($urandom_range(0, 3));
         a = rnd_val();
         b = rnd_val();
         if (md_sched_pkg::md_is_div(op) && $urandom_range(0, 7) == 0) b = 32'd0;
         if (op == 4'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd1;
         do_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
